// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: types, constants and helpers shared by the UART TX path
package uart_fifo_pkg;
    localparam int UART_DATA_WIDTH = 8;
    typedef enum logic {IDLE, LOCK} arb_state_t;
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_frame_arbiter_if.sv
// uart_tx_frame_arbiter_if: requester handshakes and TX FIFO write-port signals
interface uart_tx_frame_arbiter_if
    import uart_fifo_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic [NUM_SRC-1:0] req_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] req_data;
    logic [NUM_SRC-1:0] req_last;
    logic [NUM_SRC-1:0] req_ready;
    logic fifo_full;
    logic fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    modport slave (
        input req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data
    );
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/uart_tx_frame_arbiter_rr_priority_pick.sv
// rr_priority_pick: first valid requester after the round-robin pointer
module rr_priority_pick
    import uart_fifo_pkg::*;
#(
    parameter int N = 3,
    parameter int W = src_w(N)
) (
    input logic [N-1:0] valid,
    input logic [W-1:0] ptr,
    output logic [N-1:0] winner,
    output logic [W-1:0] index
);
    int c;
    // scan from lowest to highest priority so the nearest valid source wins last
    always_comb begin
        winner = '0;
        index = '0;
        c = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + 1 + k) % N;
            if (valid[c]) begin
                winner = '0;
                winner[c] = 1'b1;
                index = W'(c);
            end
        end
    end
endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: frame-atomic round-robin sharing of the TX FIFO write port
module uart_tx_frame_arbiter
    import uart_fifo_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int TIMEOUT = 1024,
    localparam int SRC_W = src_w(NUM_SRC),
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input logic clk,
    input logic rst,
    uart_tx_frame_arbiter_if.slave bus,
    output logic [NUM_SRC-1:0] grant,
    output logic busy,
    output logic timeout_err,
    output logic [SRC_W-1:0] timeout_src
);
    arb_state_t state, state_n;
    logic [NUM_SRC-1:0] grant_n, pick_oh;
    logic [SRC_W-1:0] gidx, gidx_n, rr_ptr, rr_ptr_n, pick_idx, timeout_src_n;
    logic g_valid, g_last, xfer, to_hit;

    rr_priority_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
        .valid(bus.req_valid),
        .ptr(rr_ptr),
        .winner(pick_oh),
        .index(pick_idx)
    );

    assign busy = state == LOCK;
    assign g_valid = |(bus.req_valid & grant);
    assign g_last = |(bus.req_last & grant);
    assign xfer = busy && g_valid && !bus.fifo_full;
    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_wr_data = xfer ? bus.req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.req_ready = (busy && !bus.fifo_full) ? grant : '0;

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [TO_W-1:0] idle_cnt;
            // a granted source holding data against a full FIFO is not stalled: count holds
            always_ff @(posedge clk or posedge rst) begin
                if (rst) idle_cnt <= '0;
                else if (!busy || xfer) idle_cnt <= '0;
                else if (!g_valid) idle_cnt <= idle_cnt + 1'b1;
            end
            assign to_hit = busy && !g_valid && idle_cnt == TO_W'(TIMEOUT - 1);
        end else begin : g_no_wd
            assign to_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            gidx <= '0;
            rr_ptr <= SRC_W'(NUM_SRC - 1);
            timeout_err <= 1'b0;
            timeout_src <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            gidx <= gidx_n;
            rr_ptr <= rr_ptr_n;
            timeout_err <= to_hit;
            timeout_src <= timeout_src_n;
        end
    end

    // releasing always returns to IDLE, which leaves a one-cycle bubble before the next grant
    always_comb begin
        state_n = state;
        grant_n = grant;
        gidx_n = gidx;
        rr_ptr_n = rr_ptr;
        timeout_src_n = timeout_src;
        if (state == IDLE) begin
            if (|bus.req_valid) begin
                state_n = LOCK;
                grant_n = pick_oh;
                gidx_n = pick_idx;
            end
        end else if ((xfer && g_last) || to_hit) begin
            state_n = IDLE;
            grant_n = '0;
            rr_ptr_n = gidx;
            timeout_src_n = to_hit ? gidx : timeout_src;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: queue-driven requesters, spec-level arbiter model checked every cycle,
// directed literal scenarios plus a randomized soak; a TIMEOUT=0 instance covers the disabled watchdog
module tb_uart_tx_frame_arbiter;
    localparam int N = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_frame_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) ifc ();
    uart_tx_frame_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) ifz ();
    logic [N-1:0] grant, grant_z;
    logic busy, busy_z, terr, terr_z;
    logic [1:0] tsrc, tsrc_z;

    uart_tx_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(ifc.slave), .grant(grant), .busy(busy),
        .timeout_err(terr), .timeout_src(tsrc)
    );
    uart_tx_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_z (
        .clk(clk), .rst(rst), .bus(ifz.slave), .grant(grant_z), .busy(busy_z),
        .timeout_err(terr_z), .timeout_src(tsrc_z)
    );

    int total = 0;
    int bad = 0;
    logic [8:0] q [N][$];
    logic [DW-1:0] wlog [$];
    logic [N-1:0] en = '0;
    logic [N-1:0] xfer = '0;
    logic full = 1'b0;
    int m_own, m_ptr, m_cnt, m_terr, m_tsrc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // requester engine: each source presents the head of its queue, popping on an observed handshake
    always @(posedge clk) begin
        #2;
        for (int s = 0; s < N; s++) begin
            if (xfer[s] && q[s].size() > 0) void'(q[s].pop_front());
            ifc.req_valid[s] = en[s] && q[s].size() > 0;
            ifc.req_data[s*DW +: DW] = (q[s].size() > 0) ? q[s][0][7:0] : '0;
            ifc.req_last[s] = q[s].size() > 0 && q[s][0][8];
        end
        ifc.fifo_full = full;
    end

    // behavioural model: owner index (-1 idle), round-robin pointer, idle-cycle count
    always @(negedge clk) begin : cmp
        int o, c;
        logic [N-1:0] eg, er;
        logic ew;
        logic [DW-1:0] ed;
        if (rst) begin
            m_own = -1; m_ptr = N - 1; m_cnt = 0; m_terr = 0; m_tsrc = 0;
        end
        o = m_own;
        eg = '0;
        ew = 1'b0;
        ed = '0;
        if (o >= 0) begin
            eg[o] = 1'b1;
            ew = ifc.req_valid[o] && !ifc.fifo_full;
            if (ew) ed = ifc.req_data[o*DW +: DW];
        end
        er = (o >= 0 && !ifc.fifo_full) ? eg : '0;
        chk("grant", grant, eg);
        chk("busy", busy, o >= 0);
        chk("req_ready", ifc.req_ready, er);
        chk("wr_en", ifc.fifo_wr_en, ew);
        if (ew || rst) chk("wr_data", ifc.fifo_wr_data, ed);
        chk("timeout_err", terr, m_terr);
        chk("timeout_src", tsrc, m_tsrc);
        xfer = ifc.req_valid & ifc.req_ready;
        if (ifc.fifo_wr_en) wlog.push_back(ifc.fifo_wr_data);
        if (!rst) begin
            m_terr = 0;
            if (o < 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + 1 + k) % N;
                    if (ifc.req_valid[c]) begin
                        m_own = c;
                        m_cnt = 0;
                        break;
                    end
                end
            end else if (ew) begin
                m_cnt = 0;
                if (ifc.req_last[o]) begin
                    m_ptr = o;
                    m_own = -1;
                end
            end else if (!ifc.req_valid[o]) begin
                m_cnt++;
                if (TO > 0 && m_cnt == TO) begin
                    m_terr = 1; m_tsrc = o; m_ptr = o; m_own = -1; m_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic negw();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        en = '0;
        full = 1'b0;
        for (int s = 0; s < N; s++) q[s].delete();
        step();
        step();
        wlog.delete();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [DW-1:0] exp_rr [12];
        int left;
        exp_rr = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h02, 8'h03, 8'h12, 8'h13, 8'h22, 8'h23};
        ifc.req_valid = '0; ifc.req_data = '0; ifc.req_last = '0; ifc.fifo_full = 1'b0;
        ifz.req_valid = '0; ifz.req_data = '0; ifz.req_last = '0; ifz.fifo_full = 1'b0;

        negw();
        chk("reset_grant", grant, 0);
        chk("reset_tsrc", tsrc, 0);

        // single source AT frame
        do_reset();
        q[1].push_back(9'h041); q[1].push_back(9'h054); q[1].push_back(9'h10D);
        en = 3'b010;
        negw(); chk("t1_c0_grant", grant, 0);
        negw(); chk("t1_c1_grant", grant, 3'b010); chk("t1_c1_wr", ifc.fifo_wr_en, 1); chk("t1_c1_data", ifc.fifo_wr_data, 8'h41);
        negw(); chk("t1_c2_wr", ifc.fifo_wr_en, 1); chk("t1_c2_data", ifc.fifo_wr_data, 8'h54);
        negw(); chk("t1_c3_wr", ifc.fifo_wr_en, 1); chk("t1_c3_data", ifc.fifo_wr_data, 8'h0D);
        negw(); chk("t1_c4_grant", grant, 0); chk("t1_c4_busy", busy, 0); chk("t1_c4_wr", ifc.fifo_wr_en, 0);

        // round robin across all sources, two 2-byte frames each
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < N; s++) begin
                q[s].push_back({1'b0, 8'(s*16 + 2*k)});
                q[s].push_back({1'b1, 8'(s*16 + 2*k + 1)});
            end
        en = 3'b111;
        left = 12;
        for (int i = 0; i < 60 && left > 0; i++) begin
            step();
            left = q[0].size() + q[1].size() + q[2].size();
        end
        chk("rr_drained", left, 0);
        chk("rr_count", wlog.size(), 12);
        for (int i = 0; i < 12; i++) chk("rr_order", (i < wlog.size()) ? wlog[i] : 8'hxx, exp_rr[i]);

        // backpressure mid-frame
        do_reset();
        q[0].push_back(9'h0A0); q[0].push_back(9'h0A1); q[0].push_back(9'h1A2);
        en = 3'b001;
        negw();
        negw(); chk("bp_b0_wr", ifc.fifo_wr_en, 1); chk("bp_b0_data", ifc.fifo_wr_data, 8'hA0);
        step(); full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            negw();
            chk("bp_full_wr", ifc.fifo_wr_en, 0);
            chk("bp_full_ready", ifc.req_ready, 0);
            chk("bp_full_terr", terr, 0);
        end
        step(); full = 1'b0;
        negw(); chk("bp_b1_wr", ifc.fifo_wr_en, 1); chk("bp_b1_data", ifc.fifo_wr_data, 8'hA1);

        // watchdog release of a stalled source
        do_reset();
        q[2].push_back(9'h055); q[2].push_back(9'h156);
        q[0].push_back(9'h001); q[0].push_back(9'h102);
        en = 3'b100;
        negw();
        negw(); chk("wd_c1_grant", grant, 3'b100); chk("wd_c1_data", ifc.fifo_wr_data, 8'h55);
        step(); en = 3'b001;
        for (int i = 0; i < 16; i++) begin
            negw();
            chk("wd_hold_grant", grant, 3'b100);
            chk("wd_hold_terr", terr, 0);
        end
        negw(); chk("wd_terr", terr, 1); chk("wd_tsrc", tsrc, 2); chk("wd_grant0", grant, 0);
        negw(); chk("wd_next_grant", grant, 3'b001); chk("wd_terr_pulse", terr, 0); chk("wd_tsrc_hold", tsrc, 2);

        // asynchronous reset mid-frame
        do_reset();
        q[1].push_back(9'h0B0); q[1].push_back(9'h0B1); q[1].push_back(9'h0B2); q[1].push_back(9'h1B3);
        en = 3'b010;
        negw();
        negw(); chk("ar_c1_wr", ifc.fifo_wr_en, 1);
        negw(); chk("ar_c2_wr", ifc.fifo_wr_en, 1);
        step(); rst = 1'b1;
        #1; chk("ar_async_grant", grant, 0); chk("ar_async_wr", ifc.fifo_wr_en, 0);
        negw(); chk("ar_rst_grant", grant, 0); chk("ar_rst_wr", ifc.fifo_wr_en, 0);
        step();
        negw(); chk("ar_rst_ready", ifc.req_ready, 0);
        step();
        q[0].push_back(9'h1C0); q[2].push_back(9'h1C2);
        rst = 1'b0; en = 3'b111;
        negw(); chk("ar_c0_grant", grant, 0);
        negw(); chk("ar_c1_grant", grant, 3'b001);

        // watchdog disabled build: a stalled owner keeps the port
        do_reset();
        ifz.req_valid = 3'b001; ifz.req_data = 24'h002211; ifz.req_last = 3'b000;
        negw();
        negw(); chk("z_c1_grant", grant_z, 3'b001); chk("z_c1_wr", ifz.fifo_wr_en, 1); chk("z_c1_data", ifz.fifo_wr_data, 8'h11);
        step(); ifz.req_valid = 3'b010; ifz.req_last = 3'b010;
        for (int i = 0; i < 100; i++) begin
            negw();
            chk("z_hold_grant", grant_z, 3'b001);
            chk("z_hold_terr", terr_z, 0);
        end
        step(); ifz.req_valid = '0;

        // randomized soak
        begin
            int stall [N];
            do_reset();
            for (int s = 0; s < N; s++) stall[s] = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                step();
                rst = ($urandom_range(0, 799) == 0);
                full = ($urandom_range(0, 3) == 0);
                for (int s = 0; s < N; s++) begin
                    if (stall[s] > 0) stall[s]--;
                    else if ($urandom_range(0, 149) == 0) stall[s] = $urandom_range(8, 30);
                    en[s] = stall[s] == 0 && $urandom_range(0, 9) != 0;
                    if (q[s].size() == 0 && $urandom_range(0, 2) == 0) begin
                        int len;
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++) q[s].push_back({b == len - 1, 8'($urandom_range(0, 255))});
                    end
                end
            end
            step(); rst = 1'b0;
            negw();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
Shares the single write port of the UART TX FIFO between NUM_SRC independent requesters (AT-command builder, status reporter, echo path, etc.). Arbitration is round-robin at frame granularity. Once a source is granted, it owns the FIFO until it writes its last byte, so frames sent to the ESP8266 are never interleaved. A per-grant inactivity watchdog releases a source that stalls mid-frame and flags an error.

Parameters:
NUM_SRC, 3, number of requesters (>=2)
DATA_WIDTH, 8, byte width; must match the TX FIFO
TIMEOUT, 1024, consecutive idle cycles tolerated mid-frame before forced release; 0 disables the watchdog
Derived: SRC_W = max(1,$clog2(NUM_SRC)); TO_W = $clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_SRC  per-source byte valid
req_data  in  NUM_SRC*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_SRC  per-source end-of-frame marker, qualified by req_valid
req_ready  out  NUM_SRC  per-source accept; byte transfers when valid&&ready
fifo_full  in  1  TX FIFO full flag
fifo_wr_en  out  1  TX FIFO write strobe
fifo_wr_data  out  DATA_WIDTH  TX FIFO write data
grant  out  NUM_SRC  one-hot current owner; all zero when idle
busy  out  1  high while a frame is locked
timeout_err  out  1  single-cycle pulse on watchdog release
timeout_src  out  SRC_W  index of the last source released by the watchdog; holds until the next timeout

Behaviour:
- Reset values: grant=0, busy=0, timeout_err=0, timeout_src=0, state=IDLE, rr_ptr=NUM_SRC-1 (source 0 has first priority), idle counter=0.
- fifo_wr_en, fifo_wr_data and req_ready are combinational from the registered grant plus fifo_full. They are 0 while rst is high.
- States: IDLE, LOCK.
- IDLE:
  - If any req_valid is high, pick the first valid source scanning (rr_ptr+1+k) mod NUM_SRC for k=0..NUM_SRC-1.
  - Register that source into grant and enter LOCK on the next edge. Arbitration latency is 1 cycle.
  - No transfers occur in IDLE; req_ready=0.
- LOCK, granted index g:
  - req_ready[g] = !fifo_full. All other ready bits are 0.
  - Transfer when req_valid[g] && !fifo_full: fifo_wr_en=1, fifo_wr_data=req_data[g]. One byte per cycle is supported back-to-back.
  - A transfer with req_last[g]=1 causes: rr_ptr<=g, grant<=0, go to IDLE. This gives a mandatory 1-cycle bubble before the next grant.
  - req_last on a cycle without a transfer is ignored.
- Watchdog (TIMEOUT>0), active in LOCK only:
  - The counter increments on cycles where req_valid[g]=0.
  - It clears on any transfer and on entry to LOCK.
  - Cycles with req_valid[g]=1 && fifo_full=1 neither count nor clear (backpressure is not a stall).
  - When the counter reaches TIMEOUT: timeout_err pulses 1 cycle, timeout_src<=g, rr_ptr<=g, grant<=0, go to IDLE.
  - The partial frame already in the FIFO is not retracted.
- TIMEOUT=0: the counter is optimised out and a locked source may hold the port indefinitely.
- A requester dropping req_valid with no transfer is legal. A source never changes req_data/req_last while valid && !ready.
- Async reset mid-frame: grant and wr_en drop immediately; after release, arbitration restarts with source 0 highest priority.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - the state enum (IDLE, LOCK)
  - the DATA_WIDTH default constant shared with the FIFO and UART TX
  - a function computing SRC_W
- One sub-module, rr_priority_pick: purely combinational. Takes the valid vector and rr_ptr; returns a one-hot winner and its index.
- All registers live in uart_tx_frame_arbiter.

Test Plan:
- NUM_SRC=3, TIMEOUT=16, single source: src1 presents 0x41,0x54,0x0D (last on 0x0D) continuously from cycle 0 -> grant=3'b010 at cycle 1; fifo_wr_en high cycles 1-3 with data 0x41,0x54,0x0D; grant=0, busy=0 at cycle 4.
- All sources valid after reset, 2-byte frames each -> FIFO receives src0,src0,src1,src1,src2,src2 bytes in that order with one idle cycle between frames. Repeat: order 0,1,2 again, never interleaved.
- Backpressure: fifo_full=1 for 5 cycles during src0's frame after byte 1 -> wr_en=0 and ready=0 for those 5 cycles; byte 2 is written on the first cycle fifo_full=0; timeout_err stays 0.
- Watchdog: src2 writes 0x55 (not last) then drops valid while src0 is valid -> after 16 idle cycles timeout_err=1 for one cycle, timeout_src=2, grant=0; next cycle grant=3'b001.
- rst asserted 2 cycles into src1's 4-byte frame -> grant=0 and wr_en=0 while rst is high; after release with all valid, src0 is granted first.
- TIMEOUT=0 build: src0 stalls mid-frame for 100 cycles with src1 valid -> grant stays 3'b001 and timeout_err never asserts.
